// File: rtl/overlay_glyph_fetch.sv
// overlay_glyph_fetch
// Tracks the active-pixel position from hs/vs/de and keeps a movable glyph
// window. Each pixel inside the window gets a font ROM address of
// offset + row*GLYPH_W + col. Sync, de and the window-hit flag are delayed so
// they line up with the ROM read data.
module overlay_glyph_fetch #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 1024,
    parameter int GLYPH_W     = 16,
    parameter int GLYPH_H     = 32,
    parameter int X_STEP      = 10,
    parameter int Y_STEP      = 18,
    parameter int X_INIT      = 300,
    parameter int Y_INIT      = 500,
    parameter int ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic        step_req,
    input  logic [12:0] glyph_offset,
    output logic [12:0] rom_address,
    output logic        overlay_enable,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos
);

    // Stage 1 (address register) plus the ROM read latency.
    localparam int DELAY = 1 + ROM_LATENCY;

    // GLYPH_W and GLYPH_H are powers of two, so {row, col} equals row*GLYPH_W + col.
    localparam int COL_W = $clog2(GLYPH_W);
    localparam int ROW_W = $clog2(GLYPH_H);

    // Largest legal left/top position. Beyond it the glyph would straddle the
    // active edge, so the position wraps back.
    localparam logic [11:0] X_LIMIT = 12'(H_ACTIVE - GLYPH_W);
    localparam logic [11:0] Y_LIMIT = 12'(V_ACTIVE - GLYPH_H);

    typedef enum logic {
        IDLE,
        ARMED
    } pos_state_t;

    pos_state_t       state;

    logic [10:0]      x_cnt;
    logic [10:0]      y_cnt;
    logic             de_prev;
    logic             vs_prev;
    logic             frame_start;

    logic [11:0]      x_cnt_w;
    logic [11:0]      y_cnt_w;
    logic [11:0]      x_lo;
    logic [11:0]      y_lo;
    logic [11:0]      x_hi;
    logic [11:0]      y_hi;
    logic             hit;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [11:0]      x_sum;
    logic [11:0]      y_sum;
    logic [11:0]      x_next;
    logic [11:0]      y_next;

    logic [DELAY-1:0] hs_pipe;
    logic [DELAY-1:0] vs_pipe;
    logic [DELAY-1:0] de_pipe;
    logic [DELAY-1:0] hit_pipe;

    // A vs falling edge marks the start of a new frame.
    assign frame_start = vs_prev & ~vs_in;

    // The window compare uses 12 bits, so position + glyph size never wraps.
    assign x_cnt_w = {1'b0, x_cnt};
    assign y_cnt_w = {1'b0, y_cnt};
    assign x_lo    = {1'b0, x_pos};
    assign y_lo    = {1'b0, y_pos};
    assign x_hi    = x_lo + 12'(GLYPH_W);
    assign y_hi    = y_lo + 12'(GLYPH_H);

    assign hit = de_in
               && (x_cnt_w >= x_lo) && (x_cnt_w < x_hi)
               && (y_cnt_w >= y_lo) && (y_cnt_w < y_hi);

    // Glyph-local coordinates. They only matter while hit is set, when they fit exactly.
    assign col = COL_W'(x_cnt - x_pos);
    assign row = ROW_W'(y_cnt - y_pos);

    // Candidate next position. It wraps so the glyph stays fully inside the active area.
    assign x_sum  = x_lo + 12'(X_STEP);
    assign y_sum  = y_lo + 12'(Y_STEP);
    assign x_next = (x_sum > X_LIMIT) ? (x_sum - X_LIMIT) : x_sum;
    assign y_next = (y_sum > Y_LIMIT) ? (y_sum - Y_LIMIT) : y_sum;

    // Pixel/line counters that describe the pixel currently on de_in, plus edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            de_prev <= 1'b0;
            vs_prev <= 1'b1;
        end else begin
            de_prev <= de_in;
            vs_prev <= vs_in;

            if (de_in) begin
                x_cnt <= x_cnt + 11'd1;
            end else begin
                x_cnt <= '0;
            end

            if (!vs_in) begin
                y_cnt <= '0;
            end else if (de_prev && !de_in) begin
                y_cnt <= y_cnt + 11'd1;
            end
        end
    end

    // Stage 1: register the ROM address, or prefetch the glyph base outside the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
        end else if (hit) begin
            rom_address <= glyph_offset + 13'({row, col});
        end else begin
            rom_address <= glyph_offset;
        end
    end

    // Delay line that keeps sync, de and the hit flag aligned with the ROM output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            de_pipe  <= '0;
            hit_pipe <= '0;
        end else begin
            hs_pipe  <= {hs_pipe[DELAY-2:0], hs_in};
            vs_pipe  <= {vs_pipe[DELAY-2:0], vs_in};
            de_pipe  <= {de_pipe[DELAY-2:0], de_in};
            hit_pipe <= {hit_pipe[DELAY-2:0], hit};
        end
    end

    assign hs_out         = hs_pipe[DELAY-1];
    assign vs_out         = vs_pipe[DELAY-1];
    assign de_out         = de_pipe[DELAY-1];
    assign overlay_enable = hit_pipe[DELAY-1];

    // Position FSM: a request seen at frame start moves the glyph exactly once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x_pos <= 11'(X_INIT);
            y_pos <= 11'(Y_INIT);
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start && step_req) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    x_pos <= 11'(x_next);
                    y_pos <= 11'(y_next);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_glyph_fetch.sv
// tb_overlay_glyph_fetch
// Drives a reduced video timing into two instances, with ROM latency 1 and 3.
// The bench checks every output on every cycle against a behavioural model
// based on frame/line/pixel indices, and adds a few hand-computed literal checks.
module tb_overlay_glyph_fetch;

    localparam int H_ACT   = 48;
    localparam int V_ACT   = 40;
    localparam int GW      = 16;
    localparam int GH      = 32;
    localparam int XS      = 10;
    localparam int YS      = 3;
    localparam int XI      = 24;
    localparam int YI      = 5;
    localparam int X_LIM   = H_ACT - GW;
    localparam int Y_LIM   = V_ACT - GH;
    localparam int H_BLANK = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hs_in;
    logic        vs_in;
    logic        de_in;
    logic        step_req;
    logic [12:0] glyph_offset;

    logic [12:0] rom_address1, rom_address3;
    logic        overlay_enable1, overlay_enable3;
    logic        hs_out1, hs_out3, vs_out1, vs_out3, de_out1, de_out3;
    logic [10:0] x_pos1, x_pos3, y_pos1, y_pos3;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit running = 1'b0;

    // Values for the next driven cycle. The driver applies them at the negedge.
    logic        nxt_reset_n;
    logic        nxt_step;
    logic [12:0] nxt_offset;

    // Expected history, indexed by the cycle that captured the input.
    logic r_hs[16];
    logic r_vs[16];
    logic r_de[16];
    int   r_hit[16];
    int   r_rom[16];
    int   r_x[16];
    int   r_y[16];

    // Model state.
    int mx, my;
    bit armed, synced, prev_vs;

    // Literal checks and reset injection hooks.
    int pin_l[2], pin_p[2], pin_v[2];
    bit lit_arm, lit_pending;
    int lit_val;
    int rst_l = -1, rst_p = -1, rst_cnt = 0;
    bit rnd_offset_en;
    int ov1_cnt, ov3_cnt;

    always #5 clk = ~clk;

    overlay_glyph_fetch #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .GLYPH_W(GW), .GLYPH_H(GH),
        .X_STEP(XS), .Y_STEP(YS), .X_INIT(XI), .Y_INIT(YI), .ROM_LATENCY(1)
    ) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .step_req(step_req), .glyph_offset(glyph_offset), .rom_address(rom_address1),
        .overlay_enable(overlay_enable1), .hs_out(hs_out1), .vs_out(vs_out1),
        .de_out(de_out1), .x_pos(x_pos1), .y_pos(y_pos1)
    );

    overlay_glyph_fetch #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .GLYPH_W(GW), .GLYPH_H(GH),
        .X_STEP(XS), .Y_STEP(YS), .X_INIT(XI), .Y_INIT(YI), .ROM_LATENCY(3)
    ) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .step_req(step_req), .glyph_offset(glyph_offset), .rom_address(rom_address3),
        .overlay_enable(overlay_enable3), .hs_out(hs_out3), .vs_out(vs_out3),
        .de_out(de_out3), .x_pos(x_pos3), .y_pos(y_pos3)
    );

    // One comparison, counted. A mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // New position after one step. It wraps so the glyph stays inside the active area.
    function automatic int stepPos(input int pos, input int step, input int lim);
        int n;
        n = pos + step;
        return (n > lim) ? n - lim : n;
    endfunction

    // Reset discards everything in flight, so the whole history becomes idle.
    task automatic clearHistory();
        for (int i = 0; i < 16; i++) begin
            r_hs[i] = 1'b1; r_vs[i] = 1'b1; r_de[i] = 1'b0;
            r_hit[i] = 0; r_rom[i] = 0; r_x[i] = XI; r_y[i] = YI;
        end
    endtask

    // Drive one cycle at the negedge and record what the DUT must show for it.
    task automatic applyStimulus(input logic hs, input logic vs, input logic de, input int p, input int l);
        int  s, hitv, romv;
        bit  rst_fall;
        @(negedge clk);
        if (lit_pending) begin
            checkOutput("rom_literal_l1", rom_address1, lit_val);
            checkOutput("rom_literal_l3", rom_address3, lit_val);
            lit_pending = 1'b0;
        end
        rst_fall     = reset_n && !nxt_reset_n;
        reset_n      = nxt_reset_n;
        hs_in        = hs;
        vs_in        = vs;
        de_in        = de;
        step_req     = nxt_step;
        glyph_offset = nxt_offset;
        if (rst_fall) begin
            #1;
            checkOutput("async_rst_overlay_l1", overlay_enable1, 0);
            checkOutput("async_rst_overlay_l3", overlay_enable3, 0);
            checkOutput("async_rst_rom_l1", rom_address1, 0);
            checkOutput("async_rst_de_out_l1", de_out1, 0);
            checkOutput("async_rst_x_pos", x_pos1, XI);
        end
        cyc++;
        s = cyc & 15;
        if (!reset_n) begin
            clearHistory();
            mx = XI; my = YI; armed = 1'b0; synced = 1'b0; prev_vs = 1'b1;
        end else begin
            if (!vs) synced = 1'b1;
            if (!de) hitv = 0;
            else if (!synced) hitv = 2;
            else hitv = (p >= mx && p < mx + GW && l >= my && l < my + GH) ? 1 : 0;
            if (hitv == 2) romv = -1;
            else if (hitv == 1) romv = (int'(nxt_offset) + (l - my) * GW + (p - mx)) % 8192;
            else romv = int'(nxt_offset);
            if (armed) begin
                mx = stepPos(mx, XS, X_LIM);
                my = stepPos(my, YS, Y_LIM);
                armed = 1'b0;
            end
            if (prev_vs && !vs && nxt_step) armed = 1'b1;
            prev_vs = vs;
            r_hs[s] = hs; r_vs[s] = vs; r_de[s] = de;
            r_hit[s] = hitv; r_rom[s] = romv; r_x[s] = mx; r_y[s] = my;
        end
        if (lit_arm) begin
            lit_pending = 1'b1;
            lit_arm = 1'b0;
        end
    endtask

    // One line: horizontal blanking with an hsync pulse, then H_ACT pixel slots.
    task automatic doLine(input logic vs, input logic act, input int l);
        for (int c = 0; c < H_BLANK; c++)
            applyStimulus((c >= 2 && c < 5) ? 1'b0 : 1'b1, vs, 1'b0, 0, l);
        for (int p = 0; p < H_ACT; p++) begin
            if (act) begin
                if (rnd_offset_en && $urandom_range(0, 15) == 0) nxt_offset = 13'($urandom);
                for (int i = 0; i < 2; i++)
                    if (l == pin_l[i] && p == pin_p[i]) begin
                        lit_arm = 1'b1;
                        lit_val = pin_v[i];
                    end
                if (l == rst_l && p == rst_p) begin
                    nxt_reset_n = 1'b0;
                    rst_cnt = 3;
                end else if (rst_cnt > 0) begin
                    rst_cnt--;
                    if (rst_cnt == 0) nxt_reset_n = 1'b1;
                end
            end
            applyStimulus(1'b1, vs, act, p, l);
        end
    endtask

    // One frame. Modes: 0 step low, 1 step held, 2 step pulsed mid-frame only, 3 random.
    task automatic doFrame(input int mode);
        ov1_cnt = 0;
        ov3_cnt = 0;
        nxt_step = (mode == 1) || (mode == 3 && $urandom_range(0, 1) == 1);
        doLine(1'b0, 1'b0, -1);
        doLine(1'b0, 1'b0, -1);
        doLine(1'b1, 1'b0, -1);
        for (int l = 0; l < V_ACT; l++) begin
            if (mode == 2 && l == 10) nxt_step = 1'b1;
            if (mode == 2 && l == 30) nxt_step = 1'b0;
            if (mode == 3 && $urandom_range(0, 7) == 0) nxt_step = ~nxt_step;
            doLine(1'b1, 1'b1, l);
        end
        doLine(1'b1, 1'b0, -1);
    endtask

    // After a full frame, check the glyph footprint and the position literals.
    task automatic checkFrame(input string tag, input int ex, input int ey, input bit full);
        checkOutput({tag, "_x_pos"}, x_pos1, ex);
        checkOutput({tag, "_y_pos"}, y_pos1, ey);
        checkOutput({tag, "_x_pos_l3"}, x_pos3, ex);
        if (full) begin
            checkOutput({tag, "_overlay_cycles_l1"}, ov1_cnt, GW * GH);
            checkOutput({tag, "_overlay_cycles_l3"}, ov3_cnt, GW * GH);
        end
    endtask

    // Compare process: every output of both instances against the model, every cycle.
    always @(posedge clk) begin
        #1;
        if (running) begin
            int s0, s1, s3;
            s0 = cyc & 15;
            s1 = (cyc - 1) & 15;
            s3 = (cyc - 3) & 15;
            if (overlay_enable1) ov1_cnt++;
            if (overlay_enable3) ov3_cnt++;
            if (!reset_n) begin
                checkOutput("rst_hs_out_l1", hs_out1, 1);
                checkOutput("rst_vs_out_l3", vs_out3, 1);
                checkOutput("rst_de_out_l1", de_out1, 0);
                checkOutput("rst_overlay_l3", overlay_enable3, 0);
                checkOutput("rst_rom_l1", rom_address1, 0);
                checkOutput("rst_y_pos_l1", y_pos1, YI);
            end else begin
                checkOutput("hs_out_l1", hs_out1, r_hs[s1]);
                checkOutput("vs_out_l1", vs_out1, r_vs[s1]);
                checkOutput("de_out_l1", de_out1, r_de[s1]);
                checkOutput("hs_out_l3", hs_out3, r_hs[s3]);
                checkOutput("vs_out_l3", vs_out3, r_vs[s3]);
                checkOutput("de_out_l3", de_out3, r_de[s3]);
                if (r_hit[s1] != 2) checkOutput("overlay_l1", overlay_enable1, r_hit[s1]);
                if (r_hit[s3] != 2) checkOutput("overlay_l3", overlay_enable3, r_hit[s3]);
                if (r_rom[s0] >= 0) begin
                    checkOutput("rom_address_l1", rom_address1, r_rom[s0]);
                    checkOutput("rom_address_l3", rom_address3, r_rom[s0]);
                end
                checkOutput("x_pos_l1", x_pos1, r_x[s0]);
                checkOutput("y_pos_l1", y_pos1, r_y[s0]);
                checkOutput("x_pos_l3", x_pos3, r_x[s0]);
                checkOutput("y_pos_l3", y_pos3, r_y[s0]);
            end
        end
    end

    // Main sequence: reset, directed frames with literal pins, then randomized frames.
    initial begin
        clearHistory();
        mx = XI; my = YI; armed = 1'b0; synced = 1'b0; prev_vs = 1'b1;
        for (int i = 0; i < 2; i++) begin pin_l[i] = -1; pin_p[i] = -1; pin_v[i] = 0; end
        lit_arm = 1'b0; lit_pending = 1'b0; lit_val = 0; rnd_offset_en = 1'b0;
        reset_n = 1'b0; nxt_reset_n = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0; step_req = 1'b0;
        glyph_offset = '0; nxt_offset = '0; nxt_step = 1'b0;
        running = 1'b1;

        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
        checkOutput("reset_x_pos", x_pos1, XI);
        checkOutput("reset_y_pos", y_pos1, YI);
        checkOutput("reset_hs_out", hs_out1, 1);
        checkOutput("reset_vs_out", vs_out3, 1);
        checkOutput("reset_rom_address", rom_address1, 0);
        nxt_reset_n = 1'b1;
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);

        $display("[TB] frame 1: fixed offset 512, address literals");
        nxt_offset = 13'd512;
        pin_l[0] = YI + 1;      pin_p[0] = XI + 5;      pin_v[0] = 533;
        pin_l[1] = YI + GH - 1; pin_p[1] = XI + GW - 1; pin_v[1] = 1023;
        doFrame(0);
        pin_l[0] = -1; pin_l[1] = -1;
        checkFrame("frame1", 24, 5, 1'b1);

        $display("[TB] frames 2-4: step_req held");
        doFrame(1); checkFrame("frame2", 2, 8, 1'b1);
        doFrame(1); checkFrame("frame3", 12, 3, 1'b1);
        doFrame(1); checkFrame("frame4", 22, 6, 1'b1);

        $display("[TB] frames 5-6: mid-frame request released before vsync");
        doFrame(2); checkFrame("frame5", 22, 6, 1'b1);
        doFrame(0); checkFrame("frame6", 22, 6, 1'b1);

        $display("[TB] frames 7-8: edge and wrap positions");
        doFrame(1); checkFrame("frame7", 32, 1, 1'b1);
        doFrame(1); checkFrame("frame8", 10, 4, 1'b1);

        $display("[TB] frame 9: reset mid-glyph, frame 10 recovers");
        rst_l = 4 + 2; rst_p = 10 + 3;
        doFrame(0);
        rst_l = -1; rst_p = -1;
        checkFrame("frame9", XI, YI, 1'b0);
        doFrame(0); checkFrame("frame10", XI, YI, 1'b1);

        $display("[TB] frames 11-14: random step_req and glyph_offset");
        rnd_offset_en = 1'b1;
        repeat (4) doFrame(3);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/overlay_glyph_fetch.md
Name: overlay_glyph_fetch

Overview:
- Sits between the video timing generator and the overlay bit repeater / bit combiner.
- Tracks the active-pixel position from hs/vs/de and maintains a movable 16x32 glyph window.
- Issues font ROM addresses as offset + row*16 + col, and delays sync, de and overlay enable by the ROM read latency so they stay aligned with ROM data.
- Replaces ad-hoc counter logic with one synchronous, pipelined stage.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 1024, active lines per frame
- GLYPH_W, 16, glyph width in pixels
- GLYPH_H, 32, glyph height in lines
- X_STEP, 10, x increment per stepped frame
- Y_STEP, 18, y increment per stepped frame
- X_INIT, 300, reset x position
- Y_INIT, 500, reset y position
- ROM_LATENCY, 1, font ROM address-to-q cycles (1..3)

Ports:
- clk  in  1  pixel clock (108 MHz)
- reset_n  in  1  asynchronous active-low reset
- hs_in  in  1  hsync from timing generator, active low
- vs_in  in  1  vsync from timing generator, active low
- de_in  in  1  data enable, active high
- step_req  in  1  level request to move glyph (KEY[1] inverted, already synchronised)
- glyph_offset  in  13  glyph base address from switch decoder
- rom_address  out  13  font ROM address
- overlay_enable  out  1  pixel is inside glyph window (aligned to ROM q)
- hs_out  out  1  hs_in delayed to match ROM data
- vs_out  out  1  vs_in delayed to match ROM data
- de_out  out  1  de_in delayed to match ROM data
- x_pos  out  11  current glyph left column
- y_pos  out  11  current glyph top line

Behaviour:
- Reset values:
  - rom_address=0, overlay_enable=0, de_out=0, hs_out=1, vs_out=1.
  - x_pos=X_INIT, y_pos=Y_INIT; internal counters 0; all pipeline stages cleared to the same idle values.
- Pixel counters, 11 bits each, updated on clk:
  - x_cnt: increments each cycle de_in=1; cleared the cycle after de_in=0.
  - y_cnt: increments on each de_in falling edge (1->0); cleared while vs_in=0.
  - x_cnt and y_cnt refer to the pixel currently presented on de_in.
- Window hit (combinational at stage 0):
  - hit = de_in and x_pos<=x_cnt<x_pos+GLYPH_W and y_pos<=y_cnt<y_pos+GLYPH_H.
  - Compare widths are 12 bits so x_pos+GLYPH_W cannot wrap.
- Address:
  - col = x_cnt-x_pos (4 bits); row = y_cnt-y_pos (5 bits).
  - Stage 1 register: rom_address = glyph_offset + {row,col}, truncated to 13 bits (wraps modulo 8192).
  - When hit=0, rom_address holds glyph_offset, so the next glyph start is prefetched.
- Latency:
  - ROM data for pixel P appears 1+ROM_LATENCY cycles after P is on de_in.
  - hs/vs/de/hit pass through a shift register of exactly 1+ROM_LATENCY stages, so overlay_enable, hs_out, vs_out and de_out change in the same cycle as the matching ROM q.
- Position state machine, states IDLE and ARMED:
  - IDLE -> ARMED on vs_in falling edge (frame start) if step_req=1.
  - ARMED -> IDLE on the next cycle, with x_pos += X_STEP and y_pos += Y_STEP applied once.
  - Exactly one move per frame, whatever the step_req duration. No move if step_req drops before the vs edge.
- Position wrap:
  - If new x_pos > H_ACTIVE-GLYPH_W, x_pos = new x_pos - (H_ACTIVE-GLYPH_W).
  - Same rule for y_pos with V_ACTIVE-GLYPH_H.
  - The glyph therefore never straddles the active edge.
- Position changes only take effect at frame start. Mid-frame glyph_offset changes take effect on the next stage-1 register (allowed to tear).
- Simultaneous events: vs edge and step_req rising in the same cycle counts as a request.
- Reset asserted mid-frame: all outputs return to reset values immediately. After release, counters resync on the next de/vs edges; the first partial frame may show no glyph.

Test Plan:
1. Reset, then drive 1280x1024 timing with offset=0. The glyph pixel at x_cnt=300, y_cnt=500 yields rom_address=0, and overlay_enable=1 exactly 2 cycles later (ROM_LATENCY=1) → then 16 cycles high per line for lines 500..531, low elsewhere.
2. At line 501, col 5 with offset=512 → rom_address=512+16+5=533. Last glyph pixel (row 31, col 15) → 1023.
3. Hold step_req=1 across 3 frames → positions (310,518), (320,536), (330,554). Step_req held only mid-frame, released before vs → no move.
4. Start from x_pos=1260 → stepping gives 1270-1264=6. Start from y_pos=990 → 1008-992=16.
5. Set ROM_LATENCY=3 → hs_out/vs_out/de_out/overlay_enable lag their inputs by exactly 4 cycles; a pulse-width-preserving check passes.
6. Assert reset_n=0 mid-glyph → overlay_enable=0 and rom_address=0 within the same cycle. Release → correct glyph on the next full frame.
